// File: rtl/i2c_master_xfer_seq.sv
// I2C transaction sequencer: turns one request into START/ADDR/DATA*/STOP commands for the byte-level controller.
// Optional build macro I2C_NACK_RETRY_EN enables address-NACK retries (up to RETRY_MAX).
`timescale 1ns/1ps

module i2c_master_xfer_seq #(
    parameter int LEN_W     = 8,
    parameter int RETRY_MAX = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [6:0]       req_addr_i,
    input  logic             req_rw_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [7:0]       wr_data_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    output logic [7:0]       rd_data_o,
    output logic             rd_valid_o,
    output logic             done_o,
    output logic             err_nack_o,
    output logic             cmd_valid_o,
    input  logic             ctrl_ready_i,
    output logic             start_o,
    output logic             stop_o,
    output logic             byte_send_o,
    output logic             byte_rcv_o,
    output logic [7:0]       byte_o,
    output logic             ack_en_o,
    input  logic             ack_received_i,
    input  logic [7:0]       rx_byte_i
);

    typedef enum logic [3:0] {
        IDLE,
        ISSUE_START, WAIT_START,
        ISSUE_ADDR,  WAIT_ADDR,
        ISSUE_WR,    WAIT_WR,
        ISSUE_RD,    WAIT_RD,
        ISSUE_STOP,  WAIT_STOP,
        DONE
    } state_t;

    state_t           state;
    logic [6:0]       addr_q;
    logic             rw_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] byte_cnt;
    logic             err_q;
    logic             busy_seen;
    logic             cmd_done;
    logic             last_byte;

`ifdef I2C_NACK_RETRY_EN
    localparam int RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    logic [RETRY_W-1:0] retry_cnt;
    logic               retry_pend;
`endif

    // A command is complete once the controller has gone busy and come back ready.
    assign cmd_done  = busy_seen && ctrl_ready_i;
    assign last_byte = (byte_cnt == len_q - 1'b1);

    // NOTE: all state and outputs are flops with async reset; update them only with <=.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            wr_ready_o  <= 1'b0;
            rd_data_o   <= '0;
            rd_valid_o  <= 1'b0;
            done_o      <= 1'b0;
            err_nack_o  <= 1'b0;
            cmd_valid_o <= 1'b0;
            start_o     <= 1'b0;
            stop_o      <= 1'b0;
            byte_send_o <= 1'b0;
            byte_rcv_o  <= 1'b0;
            byte_o      <= '0;
            ack_en_o    <= 1'b0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            len_q       <= '0;
            byte_cnt    <= '0;
            err_q       <= 1'b0;
            busy_seen   <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
            retry_cnt   <= '0;
            retry_pend  <= 1'b0;
`endif
        end else begin
            // Strobes and pulses default low; each state raises what it needs for one cycle.
            wr_ready_o  <= 1'b0;
            rd_data_o   <= '0;
            rd_valid_o  <= 1'b0;
            done_o      <= 1'b0;
            err_nack_o  <= 1'b0;
            cmd_valid_o <= 1'b0;
            start_o     <= 1'b0;
            stop_o      <= 1'b0;
            byte_send_o <= 1'b0;
            byte_rcv_o  <= 1'b0;
            byte_o      <= '0;
            ack_en_o    <= 1'b0;

            if (!ctrl_ready_i) busy_seen <= 1'b1;

            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q      <= req_addr_i;
                        rw_q        <= req_rw_i;
                        len_q       <= req_len_i;
                        byte_cnt    <= '0;
                        err_q       <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
                        retry_cnt   <= '0;
                        retry_pend  <= 1'b0;
`endif
                        req_ready_o <= 1'b0;
                        state       <= ISSUE_START;
                    end
                end

                ISSUE_START: begin
                    if (ctrl_ready_i) begin
                        cmd_valid_o <= 1'b1;
                        start_o     <= 1'b1;
                        busy_seen   <= 1'b0;
                        state       <= WAIT_START;
                    end
                end

                WAIT_START: if (cmd_done) state <= ISSUE_ADDR;

                ISSUE_ADDR: begin
                    if (ctrl_ready_i) begin
                        cmd_valid_o <= 1'b1;
                        byte_send_o <= 1'b1;
                        byte_o      <= {addr_q, rw_q};
                        busy_seen   <= 1'b0;
                        state       <= WAIT_ADDR;
                    end
                end

                WAIT_ADDR: begin
                    if (cmd_done) begin
                        if (ack_received_i) begin
`ifdef I2C_NACK_RETRY_EN
                            if (retry_cnt < RETRY_W'(RETRY_MAX)) retry_pend <= 1'b1;
                            else                                 err_q      <= 1'b1;
`else
                            err_q <= 1'b1;
`endif
                            state <= ISSUE_STOP;
                        end else if (len_q == '0) begin
                            state <= ISSUE_STOP;
                        end else if (rw_q) begin
                            state <= ISSUE_RD;
                        end else begin
                            state <= ISSUE_WR;
                        end
                    end
                end

                // Write data is taken only when both the controller and the stream are ready.
                ISSUE_WR: begin
                    if (ctrl_ready_i && wr_valid_i) begin
                        cmd_valid_o <= 1'b1;
                        byte_send_o <= 1'b1;
                        byte_o      <= wr_data_i;
                        wr_ready_o  <= 1'b1;
                        busy_seen   <= 1'b0;
                        state       <= WAIT_WR;
                    end
                end

                WAIT_WR: begin
                    if (cmd_done) begin
                        if (ack_received_i) begin
                            err_q <= 1'b1;
                            state <= ISSUE_STOP;
                        end else if (last_byte) begin
                            state <= ISSUE_STOP;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= ISSUE_WR;
                        end
                    end
                end

                ISSUE_RD: begin
                    if (ctrl_ready_i) begin
                        cmd_valid_o <= 1'b1;
                        byte_rcv_o  <= 1'b1;
                        ack_en_o    <= !last_byte;
                        busy_seen   <= 1'b0;
                        state       <= WAIT_RD;
                    end
                end

                WAIT_RD: begin
                    if (cmd_done) begin
                        rd_data_o  <= rx_byte_i;
                        rd_valid_o <= 1'b1;
                        if (last_byte) begin
                            state <= ISSUE_STOP;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= ISSUE_RD;
                        end
                    end
                end

                ISSUE_STOP: begin
                    if (ctrl_ready_i) begin
                        cmd_valid_o <= 1'b1;
                        stop_o      <= 1'b1;
                        busy_seen   <= 1'b0;
                        state       <= WAIT_STOP;
                    end
                end

                WAIT_STOP: begin
                    if (cmd_done) begin
`ifdef I2C_NACK_RETRY_EN
                        if (retry_pend) begin
                            retry_pend <= 1'b0;
                            retry_cnt  <= retry_cnt + 1'b1;
                            state      <= ISSUE_START;
                        end else begin
                            done_o     <= 1'b1;
                            err_nack_o <= err_q;
                            state      <= DONE;
                        end
`else
                        done_o     <= 1'b1;
                        err_nack_o <= err_q;
                        state      <= DONE;
`endif
                    end
                end

                DONE: begin
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end

                default: begin
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
